// File: rtl/comparator.sv
// -----------------------------------------------------------------------------
// comparator
//   Registered 4-bit unsigned magnitude comparator. Operands arrive as eight
//   single-bit ports. The greater/equal/less decision is formed combinationally
//   with an MSB-first priority scan, then captured on the rising clock edge.
//   This gives one cycle of latency and no input-to-output combinational path.
//
// Ports
//   clk            in   clock, all state updates on rising edge
//   rst_n          in   async active-low reset, clears g/e/l to 0
//   A3..A0         in   operand A, A3 is the MSB
//   B3..B0         in   operand B, B3 is the MSB
//   g              out  registered A >  B
//   e              out  registered A == B
//   l              out  registered A <  B
// -----------------------------------------------------------------------------
module comparator (
  input  logic clk,
  input  logic rst_n,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  output logic g,
  output logic e,
  output logic l
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic       w_gt;
  logic       w_lt;
  logic       w_eq;

  logic       r_g;
  logic       r_e;
  logic       r_l;

  assign w_a = {A3, A2, A1, A0};
  assign w_b = {B3, B2, B1, B0};

  // The scan runs from the MSB down. The first differing bit latches the
  // decision. Once it is decided, lower bits are ignored.
  always_comb begin
    w_gt = 1'b0;
    w_lt = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!w_gt && !w_lt) begin
        if (w_a[i] && !w_b[i])      w_gt = 1'b1;
        else if (!w_a[i] && w_b[i]) w_lt = 1'b1;
      end
    end
  end

  assign w_eq = ~(w_gt | w_lt);

  // All-zero is only seen in reset. Out of reset the flops always hold a
  // one-hot result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g <= 1'b0;
      r_e <= 1'b0;
      r_l <= 1'b0;
    end else begin
      r_g <= w_gt;
      r_e <= w_eq;
      r_l <= w_lt;
    end
  end

  assign g = r_g;
  assign e = r_e;
  assign l = r_l;

endmodule

// File: tb/tb_comparator.sv
// -----------------------------------------------------------------------------
// tb_comparator
//   Directed self-checking bench for comparator. Results are compared as the
//   3-bit vector {g,e,l}. Inputs change 1ns after a rising edge, and outputs
//   are sampled at the same time, so the sample point is never on the edge.
// -----------------------------------------------------------------------------
module tb_comparator;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       g, e, l;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] GT   = 3'b100;
  localparam logic [2:0] EQ   = 3'b010;
  localparam logic [2:0] LT   = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  comparator dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A3   (a[3]),
    .A2   (a[2]),
    .A1   (a[1]),
    .A0   (a[0]),
    .B3   (b[3]),
    .B2   (b[2]),
    .B1   (b[1]),
    .B0   (b[0]),
    .g    (g),
    .e    (e),
    .l    (l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gel=%b expected gel=%b", tag, act, exp);
    end
  endtask

  // Advance one rising edge and step 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp;

    // Reset is held with A=9, B=3 while the clock runs.
    rst_n = 1'b0;
    a = 4'd9;
    b = 4'd3;
    #2;
    chk("reset_async", {g, e, l}, NONE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", {g, e, l}, NONE);
    end

    // Release reset between edges. The first edge afterwards loads 9 > 3.
    #2 rst_n = 1'b1;
    tick();
    chk("reset_release", {g, e, l}, GT);

    // Boundary and MSB-dominance vectors with hand-computed results.
    a = 4'd0;  b = 4'd0;  tick(); chk("a0_b0",   {g, e, l}, EQ);
    a = 4'd15; b = 4'd15; tick(); chk("a15_b15", {g, e, l}, EQ);
    a = 4'd0;  b = 4'd15; tick(); chk("a0_b15",  {g, e, l}, LT);
    a = 4'd15; b = 4'd0;  tick(); chk("a15_b0",  {g, e, l}, GT);
    a = 4'd8;  b = 4'd7;  tick(); chk("msb_8_7", {g, e, l}, GT);
    a = 4'd7;  b = 4'd8;  tick(); chk("msb_7_8", {g, e, l}, LT);
    a = 4'd5;  b = 4'd5;  tick(); chk("eq_5_5",  {g, e, l}, EQ);

    // Full sweep, one pair per clock. Each result is checked one edge later.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        a = 4'(ia);
        b = 4'(ib);
        tick();
        exp = (ia > ib) ? GT : ((ia == ib) ? EQ : LT);
        chk($sformatf("sweep_%0d_%0d", ia, ib), {g, e, l}, exp);
        chk("onehot", 3'($countones({g, e, l})), 3'd1);
      end
    end

    // Latency and hold: A changes 2 -> 12 between edges with B=6.
    a = 4'd2; b = 4'd6;
    tick();
    chk("hold_pre", {g, e, l}, LT);
    #2 a = 4'd12;
    #1 chk("hold_mid", {g, e, l}, LT);
    tick();
    chk("hold_post", {g, e, l}, GT);

    // Async reset mid-run with A=B=10. Outputs clear before the next edge.
    a = 4'd10; b = 4'd10;
    tick();
    chk("pre_rst_eq", {g, e, l}, EQ);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_async", {g, e, l}, NONE);
    tick();
    chk("mid_rst_hold", {g, e, l}, NONE);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_rst_release", {g, e, l}, EQ);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits per operand.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous assert and active-low.
REQ-004 A3  input  1  Operand A, bit 3 (MSB).
REQ-005 A2  input  1  Operand A, bit 2.
REQ-006 A1  input  1  Operand A, bit 1.
REQ-007 A0  input  1  Operand A, bit 0 (LSB).
REQ-008 B3  input  1  Operand B, bit 3 (MSB).
REQ-009 B2  input  1  Operand B, bit 2.
REQ-010 B1  input  1  Operand B, bit 1.
REQ-011 B0  input  1  Operand B, bit 0 (LSB).
REQ-012 g  output  1  A greater than B.
REQ-013 e  output  1  A equal to B.
REQ-014 l  output  1  A less than B.
REQ-015 Port order SHALL be clk, rst_n, A3, A2, A1, A0, B3, B2, B1, B0, g, e, l.

Function
REQ-016 A = {A3,A2,A1,A0} and B = {B3,B2,B1,B0} SHALL be treated as unsigned integers, 0..15.
REQ-017 Comparison SHALL be MSB-first: the first differing bit position from bit 3 down decides the result. If A has 1 and B has 0 at that bit, A > B. If A has 0 and B has 1 at that bit, A < B.
REQ-018 If no bit differs, the result SHALL be equal.
REQ-019 The comparison result SHALL be computed combinationally from the current inputs.
REQ-020 The result SHALL be registered into g, e and l on every rising clk edge, giving exactly one cycle of latency.
REQ-021 Each edge sample SHALL set g=1 only when A > B, e=1 only when A == B, and l=1 only when A < B.
REQ-022 Outside reset, exactly one of g, e, l SHALL be 1 (one-hot) after the first post-reset clock edge.
REQ-023 Outputs SHALL hold their value between rising edges regardless of input changes.
REQ-024 Input changes SHALL affect outputs only at the next rising edge; there is no combinational input-to-output path.
REQ-025 Boundary cases SHALL produce:
  - A=0,B=0 -> e.
  - A=15,B=15 -> e.
  - A=0,B=15 -> l.
  - A=15,B=0 -> g.
REQ-026 X/Z on any input SHALL NOT be required to resolve; behaviour is defined only for 0/1 inputs.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force g=0, e=0, l=0.
REQ-028 Outputs SHALL remain all 0 while rst_n is low, irrespective of clk and inputs.
REQ-029 After rst_n rises, the first rising clk edge SHALL load the comparison of the inputs present at that edge.
REQ-030 Reset asserted mid-operation SHALL discard the held result. There is no other internal state to clear.

Verification
REQ-031 Reset: rst_n=0 with A=9, B=3, clk toggling -> g=e=l=0 throughout; release, one edge -> g=1,e=0,l=0.
REQ-032 Exhaustive sweep: all 256 (A,B) pairs, one per clock -> each result one cycle later matches unsigned compare and is one-hot.
REQ-033 MSB dominance: A=8 (1000), B=7 (0111) -> g=1. A=7, B=8 -> l=1. A=5, B=5 -> e=1.
REQ-034 Latency/hold: change A=2→12 with B=6 between edges -> l stays 1 until next edge, then g=1.
REQ-035 Async reset mid-run: with e=1 (A=B=10), drop rst_n between edges -> all outputs 0 immediately, before next clk.
